// File: rtl/jtkcpu_pshpul_if.sv
// Stack-memory bus between the push/pull sequencer (master) and the memory side (slave).
interface jtkcpu_pshpul_if;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_dout,
    input  bus_din, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_dout,
    output bus_din, bus_ack
  );
endinterface

// File: rtl/jtkcpu_pshpul.sv
// KCPU push/pull sequencer: walks the postbyte mask byte by byte, issues stack transfers
// and returns the final stack pointer.
//
// state   | meaning
// IDLE    | waiting for start_psh / start_pul
// PICK    | select next register byte (push pre-decrements addr)
// XFER    | bus transfer held until bus_ack with cen
// DONE    | one-cycle end pulse, sp_out valid
module jtkcpu_pshpul (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        start_psh,
  input  logic        start_pul,
  input  logic [7:0]  postbyte,
  input  logic [15:0] sp_in,
  input  logic [7:0]  psh_mux,
  output logic [7:0]  psh_sel,
  output logic        psh_hilon,
  output logic        pul_en,
  output logic [7:0]  pul_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] sp_out,
  jtkcpu_pshpul_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PICK = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  mask;
  logic [15:0] addr;
  logic        dir;
  logic        second;

  logic [2:0]  cur_idx;
  logic        wide;
  logic        last_byte;
  logic [7:0]  rest;
  logic        start_any;
  logic        ack_ok;
  logic        sel_act;

  // Push walks from PC down to CC, pull from CC up to PC.
  always_comb begin
    cur_idx = 3'd0;
    if (dir) begin
      for (int i = 0; i < 8; i++)
        if (mask[i]) cur_idx = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (mask[i]) cur_idx = 3'(i);
    end
  end

  assign wide      = cur_idx[2];
  assign last_byte = !wide || second;
  assign rest      = mask & ~(8'd1 << cur_idx);
  assign start_any = start_psh || start_pul;
  assign ack_ok    = bus.bus_ack && cen;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (cen && start_any) state_nx = (postbyte == 8'd0) ? ST_DONE : ST_PICK;
      ST_PICK: if (cen) state_nx = ST_XFER;
      ST_XFER: if (ack_ok) state_nx = (!last_byte || rest != 8'd0) ? ST_PICK : ST_DONE;
      ST_DONE: if (cen) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask   <= 8'd0;
      addr   <= 16'd0;
      dir    <= 1'b0;
      second <= 1'b0;
    end else if (cen) begin
      case (state)
        ST_IDLE: if (start_any) begin
          mask   <= postbyte;
          addr   <= sp_in;
          dir    <= start_psh;
          second <= 1'b0;
        end
        ST_PICK: if (dir) addr <= addr - 16'd1;
        ST_XFER: if (bus.bus_ack) begin
          if (!dir) addr <= addr + 16'd1;
          if (!last_byte) second <= 1'b1;
          else begin
            mask   <= rest;
            second <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Push stores low byte first (higher address); pull reads high byte first.
  always_comb begin
    sel_act      = (state == ST_PICK) || (state == ST_XFER);
    psh_sel      = sel_act ? (8'd1 << cur_idx) : 8'd0;
    psh_hilon    = sel_act && wide && (dir ? second : !second);
    bus.bus_req  = (state == ST_XFER);
    bus.bus_we   = (state == ST_XFER) && dir;
    bus.bus_addr = (state == ST_XFER) ? addr : 16'd0;
    bus.bus_dout = psh_mux;
    pul_en       = (state == ST_XFER) && !dir && bus.bus_ack && cen;
    pul_data     = bus.bus_din;
    busy         = (state != ST_IDLE);
    done         = (state == ST_DONE);
    sp_out       = (state == ST_DONE) ? addr : 16'd0;
  end

endmodule

// File: tb/tb_jtkcpu_pshpul.sv
// Directed bench for jtkcpu_pshpul: vector table of push/pull sequences against a byte memory
// model, plus a reset-abort sequence.
module tb_jtkcpu_pshpul;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b1;
  logic        start_psh = 1'b0;
  logic        start_pul = 1'b0;
  logic [7:0]  postbyte = 8'd0;
  logic [15:0] sp_in = 16'd0;
  logic [7:0]  psh_mux;
  logic [7:0]  psh_sel;
  logic        psh_hilon;
  logic        pul_en;
  logic [7:0]  pul_data;
  logic        busy;
  logic        done;
  logic [15:0] sp_out;

  jtkcpu_pshpul_if bus_if ();

  jtkcpu_pshpul dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .start_psh (start_psh),
    .start_pul (start_pul),
    .postbyte  (postbyte),
    .sp_in     (sp_in),
    .psh_mux   (psh_mux),
    .psh_sel   (psh_sel),
    .psh_hilon (psh_hilon),
    .pul_en    (pul_en),
    .pul_data  (pul_data),
    .busy      (busy),
    .done      (done),
    .sp_out    (sp_out),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] reg_byte(input int b, input logic hi);
    case (b)
      0: return 8'hC1;
      1: return 8'hA2;
      2: return 8'hB3;
      3: return 8'hD4;
      4: return hi ? 8'h12 : 8'h34;
      5: return hi ? 8'h56 : 8'h78;
      6: return hi ? 8'h9A : 8'hBC;
      default: return hi ? 8'hDE : 8'hF0;
    endcase
  endfunction

  // Register-file stand-in answering the current select.
  always_comb begin
    psh_mux = 8'h00;
    for (int b = 0; b < 8; b++)
      if (psh_sel[b]) psh_mux = reg_byte(b, psh_hilon);
  end

  // Log entry: {we, addr, data, sel, hilon, pul_en}
  logic [34:0] log_q[$];
  logic [34:0] exp_q[$];
  logic [7:0]  mem [65536];

  int  wait_cfg = 0;
  int  wait_cnt = 0;
  bit  tog = 1'b0;
  bit  spur = 1'b0;
  bit  held_v = 1'b0;
  logic [33:0] held;
  logic [33:0] cur;
  logic fire;

  initial begin
    bus_if.bus_ack = 1'b0;
    bus_if.bus_din = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  end

  // Memory model: decides ack/cen for the coming edge, then logs the transfer that edge completes.
  always @(negedge clk) begin
    if (bus_if.bus_req) begin
      bus_if.bus_ack = (wait_cnt >= wait_cfg);
      wait_cnt++;
    end else begin
      bus_if.bus_ack = spur;
      wait_cnt = 0;
    end
    cen = tog ? ~cen : 1'b1;
    bus_if.bus_din = mem[bus_if.bus_addr];
    #1;
    fire = bus_if.bus_ack && cen && bus_if.bus_req;
    chk("pul_en_strobe", {63'd0, pul_en}, {63'd0, fire && !bus_if.bus_we});
    cur = {bus_if.bus_we, bus_if.bus_addr, bus_if.bus_dout, psh_sel, psh_hilon};
    if (bus_if.bus_req) begin
      if (held_v) chk("xfer_hold", {30'd0, cur}, {30'd0, held});
      else begin
        held   = cur;
        held_v = 1'b1;
      end
    end else held_v = 1'b0;
    if (fire) begin
      log_q.push_back({bus_if.bus_we, bus_if.bus_addr,
                       bus_if.bus_we ? bus_if.bus_dout : pul_data,
                       psh_sel, psh_hilon, pul_en});
      if (bus_if.bus_we) mem[bus_if.bus_addr] = bus_if.bus_dout;
      held_v = 1'b0;
    end
  end

  typedef struct {
    bit          psh;
    bit          both;
    logic [7:0]  pb;
    logic [15:0] sp;
    logic [15:0] exp_sp;
    int          cyc;
    int          wt;
    bit          tg;
    bit          sp_ack;
  } vec_t;

  vec_t vecs[12];

  task automatic build_exp(input bit psh, input logic [7:0] pb, input logic [15:0] sp);
    logic [15:0] a;
    exp_q.delete();
    a = sp;
    if (psh) begin
      for (int b = 7; b >= 0; b--) begin
        if (pb[b]) begin
          if (b >= 4) begin
            a = a - 16'd1;
            exp_q.push_back({1'b1, a, reg_byte(b, 1'b0), 8'(1 << b), 1'b0, 1'b0});
            a = a - 16'd1;
            exp_q.push_back({1'b1, a, reg_byte(b, 1'b1), 8'(1 << b), 1'b1, 1'b0});
          end else begin
            a = a - 16'd1;
            exp_q.push_back({1'b1, a, reg_byte(b, 1'b0), 8'(1 << b), 1'b0, 1'b0});
          end
        end
      end
    end else begin
      for (int b = 0; b < 8; b++) begin
        if (pb[b]) begin
          if (b >= 4) begin
            exp_q.push_back({1'b0, a, reg_byte(b, 1'b1), 8'(1 << b), 1'b1, 1'b1});
            a = a + 16'd1;
            exp_q.push_back({1'b0, a, reg_byte(b, 1'b0), 8'(1 << b), 1'b0, 1'b1});
            a = a + 16'd1;
          end else begin
            exp_q.push_back({1'b0, a, reg_byte(b, 1'b0), 8'(1 << b), 1'b0, 1'b1});
            a = a + 16'd1;
          end
        end
      end
    end
  endtask

  task automatic run_seq(input vec_t v, input int idx);
    int n;
    bit got;
    int nb;
    build_exp(v.psh || v.both, v.pb, v.sp);
    log_q.delete();
    @(negedge clk);
    wait_cfg  = v.wt;
    tog       = v.tg;
    spur      = v.sp_ack;
    postbyte  = v.pb;
    sp_in     = v.sp;
    start_psh = v.psh || v.both;
    start_pul = !v.psh || v.both;
    n = 0;
    got = 1'b0;
    while (!got && n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      #2;
      if (busy && (start_psh || start_pul)) begin
        start_psh = 1'b0;
        start_pul = 1'b0;
      end
      if (done) got = 1'b1;
    end
    start_psh = 1'b0;
    start_pul = 1'b0;
    chk($sformatf("v%0d_done_seen", idx), {63'd0, got}, 64'd1);
    if (got) begin
      chk($sformatf("v%0d_sp_out", idx), {48'd0, sp_out}, {48'd0, v.exp_sp});
      if (v.cyc != 0) chk($sformatf("v%0d_latency", idx), 64'(n + 1), 64'(v.cyc));
      nb = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
      chk($sformatf("v%0d_nbytes", idx), 64'(log_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < nb; i++)
        chk($sformatf("v%0d_xfer%0d", idx, i), {29'd0, log_q[i]}, {29'd0, exp_q[i]});
      if (!v.tg) begin
        @(negedge clk);
        #2;
        chk($sformatf("v%0d_done_pulse", idx), {63'd0, done}, 64'd0);
      end
    end
    tog = 1'b0;
    spur = 1'b0;
    wait_cfg = 0;
    for (int k = 0; k < 10 && (busy || !cen); k++) begin
      @(negedge clk);
      #2;
    end
  endtask

  initial begin
    vecs[0]  = '{1, 0, 8'h81, 16'h1000, 16'h0FFD,  8, 0, 0, 0};
    vecs[1]  = '{0, 0, 8'h81, 16'h0FFD, 16'h1000,  8, 0, 0, 0};
    vecs[2]  = '{1, 0, 8'h00, 16'h2345, 16'h2345,  2, 0, 0, 0};
    vecs[3]  = '{1, 0, 8'h01, 16'h0000, 16'hFFFF,  4, 0, 0, 0};
    vecs[4]  = '{0, 0, 8'h01, 16'hFFFF, 16'h0000,  4, 0, 0, 0};
    vecs[5]  = '{1, 0, 8'hFF, 16'h3000, 16'h2FF4, 26, 0, 0, 0};
    vecs[6]  = '{0, 0, 8'hFF, 16'h2FF4, 16'h3000, 26, 0, 0, 0};
    vecs[7]  = '{1, 0, 8'h36, 16'h4000, 16'h3FFA,  0, 3, 1, 0};
    vecs[8]  = '{0, 0, 8'h36, 16'h3FFA, 16'h4000,  0, 3, 1, 0};
    vecs[9]  = '{0, 0, 8'h00, 16'h5555, 16'h5555,  2, 0, 0, 1};
    vecs[10] = '{1, 0, 8'h0C, 16'h6000, 16'h5FFE,  6, 0, 0, 1};
    vecs[11] = '{1, 1, 8'h02, 16'h7000, 16'h6FFF,  4, 0, 0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    chk("rst_psh_sel", {56'd0, psh_sel}, 64'd0);
    chk("rst_flags", {58'd0, psh_hilon, pul_en, bus_if.bus_req, bus_if.bus_we, done, busy}, 64'd0);
    chk("rst_bus_addr", {48'd0, bus_if.bus_addr}, 64'd0);
    chk("rst_sp_out", {48'd0, sp_out}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_seq(vecs[i], i);

    // Abort a push of X/Y after two bytes, then run a clean pull of Y.
    log_q.delete();
    @(negedge clk);
    postbyte  = 8'h30;
    sp_in     = 16'h8000;
    start_psh = 1'b1;
    for (int k = 0; k < 50 && log_q.size() < 2; k++) begin
      @(negedge clk);
      #2;
      if (busy) start_psh = 1'b0;
    end
    start_psh = 1'b0;
    chk("abort_two_bytes", 64'(log_q.size()), 64'd2);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #2;
    chk("abort_bus_req", {63'd0, bus_if.bus_req}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_bytes", 64'(log_q.size()), 64'd2);
    rst = 1'b0;
    run_seq('{0, 0, 8'h20, 16'h7FFE, 16'h8000, 6, 0, 0, 0}, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
